// File: rtl/stack_lifo_pkg.sv
// Shared definitions for the LIFO stack: the request op codes and their decode.
package stack_lifo_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({pop, push});
  endfunction

endpackage

// File: rtl/stack_lifo_ctrl.sv
// Request decoder for the LIFO stack: turns Push/Pop plus occupancy into
// storage, pointer and output-register controls.
module stack_lifo_ctrl
  import stack_lifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [CW-1:0] i_count,
  output logic          o_wr_en,
  output logic          o_wr_top,
  output logic          o_rd_en,
  output logic          o_inc,
  output logic          o_dec,
  output logic          o_pass,
  output logic          o_ovf_nxt,
  output logic          o_unf_nxt
);

  op_e  w_op;
  logic w_full;
  logic w_empty;

  assign w_op    = decode_op(i_push, i_pop);
  assign w_full  = (i_count == CW'(DEPTH));
  assign w_empty = (i_count == CW'(0));

  // Refused requests produce only a status pulse, so sp stays within 0..DEPTH
  always_comb begin
    o_wr_en   = 1'b0;
    o_wr_top  = 1'b0;
    o_rd_en   = 1'b0;
    o_inc     = 1'b0;
    o_dec     = 1'b0;
    o_pass    = 1'b0;
    o_ovf_nxt = 1'b0;
    o_unf_nxt = 1'b0;
    case (w_op)
      OP_PUSH: begin
        if (w_full) begin
          o_ovf_nxt = 1'b1;
        end else begin
          o_wr_en = 1'b1;
          o_inc   = 1'b1;
        end
      end
      OP_POP: begin
        if (w_empty) begin
          o_unf_nxt = 1'b1;
        end else begin
          o_rd_en = 1'b1;
          o_dec   = 1'b1;
        end
      end
      OP_SWAP: begin
        if (w_empty) begin
          o_pass = 1'b1;
        end else begin
          o_rd_en  = 1'b1;
          o_wr_en  = 1'b1;
          o_wr_top = 1'b1;
        end
      end
      default: begin
        o_wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/stack_lifo.sv
// Synchronous LIFO stack with registered pop data, occupancy status and
// one-cycle overflow/underflow pulses.
module stack_lifo
  import stack_lifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             ClrN,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] DIn,
  output logic [WIDTH-1:0] DOut,
  output logic             Full,
  output logic             Empty,
  output logic [CW-1:0]    Count,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_sp;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_unf;

  logic          w_wr_en;
  logic          w_wr_top;
  logic          w_rd_en;
  logic          w_inc;
  logic          w_dec;
  logic          w_pass;
  logic          w_ovf_nxt;
  logic          w_unf_nxt;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_wr_idx;

  stack_lifo_ctrl #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_ctrl (
    .i_push    (Push),
    .i_pop     (Pop),
    .i_count   (r_sp),
    .o_wr_en   (w_wr_en),
    .o_wr_top  (w_wr_top),
    .o_rd_en   (w_rd_en),
    .o_inc     (w_inc),
    .o_dec     (w_dec),
    .o_pass    (w_pass),
    .o_ovf_nxt (w_ovf_nxt),
    .o_unf_nxt (w_unf_nxt)
  );

  // Low pointer bits minus one wrap correctly to DEPTH-1 when sp == DEPTH
  assign w_top_idx = r_sp[AW-1:0] - AW'(1);
  assign w_wr_idx  = w_wr_top ? w_top_idx : r_sp[AW-1:0];

  // Storage has no reset; a swap reads the old top before it is overwritten
  always_ff @(posedge CLK) begin
    if (ClrN && w_wr_en) begin
      r_mem[w_wr_idx] <= DIn;
    end
  end

  // Pointer, output data and status pulses
  always_ff @(posedge CLK) begin
    if (!ClrN) begin
      r_sp   <= CW'(0);
      r_dout <= WIDTH'(0);
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_inc) begin
        r_sp <= r_sp + CW'(1);
      end else if (w_dec) begin
        r_sp <= r_sp - CW'(1);
      end
      if (w_rd_en) begin
        r_dout <= r_mem[w_top_idx];
      end else if (w_pass) begin
        r_dout <= DIn;
      end
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
    end
  end

  assign DOut      = r_dout;
  assign Count     = r_sp;
  assign Full      = (r_sp == CW'(DEPTH));
  assign Empty     = (r_sp == CW'(0));
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;

endmodule
